// File: rtl/wb_stage.sv
// Write-back stage: merges the in-order pipeline result with a one-entry buffer
// holding long-latency (mul/div) results onto a single register-file write port.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_word,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        wb_stall,
  output logic        RegWrite,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  age_q, age_d;
  logic        lb_valid_q, lb_valid_d;
  logic [4:0]  lb_rd_q, lb_rd_d;
  logic [31:0] lb_data_q, lb_data_d;
  logic        wb_stall_q, wb_stall_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;

  logic [7:0]  load_bytes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] cand_data;
  logic        cand;
  logic        squash;
  logic        capture;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign load_bytes[gi] = mem_load_word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = load_bytes[mem_alu_result[1:0]];
  assign sel_half = mem_alu_result[1] ? mem_load_word[31:16] : mem_load_word[15:0];

  always_comb begin
    case (mem_funct3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = mem_load_word;
    endcase
  end

  assign cand_data = mem_memtoreg ? load_data : mem_alu_result;
  // A stalled cycle ignores MEM inputs entirely so the buffer owns the port.
  assign cand      = mem_valid & mem_regwrite & (mem_rd != 5'd0) & ~wb_stall_q;
  assign squash    = cand & lb_valid_q & (mem_rd == lb_rd_q);
  assign lu_ready  = rst_n & ~lb_valid_q;
  assign capture   = lu_valid & lu_ready;

  always_comb begin
    state_d      = state_q;
    age_d        = age_q;
    lb_valid_d   = lb_valid_q;
    lb_rd_d      = lb_rd_q;
    lb_data_d    = lb_data_q;
    wb_stall_d   = 1'b0;
    regwrite_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    if (cand) begin
      regwrite_d   = 1'b1;
      write_addr_d = mem_rd;
      write_data_d = cand_data;
      if (squash) begin
        lb_valid_d = 1'b0;
      end
    end else if (lb_valid_q) begin
      regwrite_d   = 1'b1;
      write_addr_d = lb_rd_q;
      write_data_d = lb_data_q;
      lb_valid_d   = 1'b0;
    end

    // Results for x0 are accepted to free the unit but never buffered.
    if (capture && (lu_rd != 5'd0)) begin
      lb_valid_d = 1'b1;
      lb_rd_d    = lu_rd;
      lb_data_d  = lu_data;
    end

    case (state_q)
      ST_IDLE: begin
        age_d = 2'd0;
        if (capture && (lu_rd != 5'd0)) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!cand || squash) begin
          state_d = ST_IDLE;
          age_d   = 2'd0;
        end else if (age_q == 2'd1) begin
          state_d    = ST_FORCE;
          age_d      = 2'd2;
          wb_stall_d = 1'b1;
        end else begin
          age_d = age_q + 2'd1;
        end
      end
      ST_FORCE: begin
        state_d = ST_IDLE;
        age_d   = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
        age_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      age_q        <= 2'd0;
      lb_valid_q   <= 1'b0;
      lb_rd_q      <= 5'd0;
      lb_data_q    <= 32'd0;
      wb_stall_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      write_addr_q <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      age_q        <= age_d;
      lb_valid_q   <= lb_valid_d;
      lb_rd_q      <= lb_rd_d;
      lb_data_q    <= lb_data_d;
      wb_stall_q   <= wb_stall_d;
      regwrite_q   <= regwrite_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign wb_stall  = wb_stall_q;
  assign RegWrite  = regwrite_q;
  assign WriteAddr = write_addr_q;
  assign WriteData = write_data_q;

endmodule
